// File: rtl/uart_rx.sv
// 8N1 (or 8E1 with UART_RX_PARITY_EN) asynchronous serial receiver, LSB first,
// mid-bit sampling driven by a reloadable bit-width down-counter.
module uart_rx #(
    parameter int unsigned FCLK = 100000000,
    parameter int unsigned BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned BIT_LOAD  = FCLK / BAUD - 1;
    localparam int unsigned HALF_LOAD = BIT_LOAD / 2;
    localparam int unsigned CW        = (BIT_LOAD < 1) ? 1 : $clog2(BIT_LOAD + 1);

    localparam logic [CW-1:0] BIT_LD  = CW'(BIT_LOAD);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF_LOAD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state, state_nx;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [7:0]    data_nx;
    logic          valid_nx, ferr_nx, busy_nx;
    logic          sample;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_nx, perr_nx;
`endif

    // Two-stage synchronizer; idle-high reset so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_cnt   <= bit_nx;
            shreg     <= shreg_nx;
            rx_data   <= data_nx;
            rx_valid  <= valid_nx;
            frame_err <= ferr_nx;
            busy      <= busy_nx;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_nx;
            parity_err <= perr_nx;
`endif
        end
    end

    assign sample = (cnt == '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = sample ? cnt : cnt - CW'(1);
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        data_nx  = rx_data;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx  = par_bit;
        perr_nx = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_nx   = HALF_LD;
                    state_nx = START;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx   = BIT_LD;
                        bit_nx   = '0;
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_nx[bit_cnt] = rx_s;
                    cnt_nx            = BIT_LD;
                    bit_nx            = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    par_nx   = rx_s;
                    cnt_nx   = BIT_LD;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
                        if ((^shreg) ^ par_bit) begin
                            perr_nx = 1'b1;
                        end else begin
                            data_nx  = shreg;
                            valid_nx = 1'b1;
                        end
`else
                        data_nx  = shreg;
                        valid_nx = 1'b1;
`endif
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk/bit; an expected-event queue models each
// frame's outcome and a per-cycle compare process checks pulses and held data.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.FCLK(1600), .BAUD(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    // kind: 0 = good byte, 1 = stop-bit error, 2 = parity error
    typedef struct {
        int          kind;
        logic [7:0]  data;
        int unsigned t0;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  last_good = 8'h00;
    int          checks = 0, failures = 0;
    int          n_valid = 0, n_ferr = 0, n_perr = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Frame outcome is due ~155 clks after the start edge (171 with parity).
    always @(negedge clk) begin
        logic [2:0] pulses;
        ev_t        e;
        if (!rst_n) begin
            last_good = 8'h00;
        end else begin
`ifdef UART_RX_PARITY_EN
            pulses = {parity_err, frame_err, rx_valid};
`else
            pulses = {1'b0, frame_err, rx_valid};
`endif
            if (rx_valid)   n_valid++;
            if (pulses[1])  n_ferr++;
            if (pulses[2])  n_perr++;
            if (pulses != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, pulses}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {29'd0, pulses}, 32'd1 << e.kind);
                    check("pulse_latency", {31'd0, (cyc - e.t0 >= 140) && (cyc - e.t0 <= 190)}, 32'd1);
                    if (e.kind == 0) last_good = e.data;
                end
            end else if (exp_q.size() != 0 && (cyc - exp_q[0].t0) > 190) begin
                check("pulse_timeout", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
        ev_t e;
        e.t0   = cyc;
        e.data = d;
`ifdef UART_RX_PARITY_EN
        e.kind = !stop_bit ? 1 : (!par_ok ? 2 : 0);
`else
        e.kind = !stop_bit ? 1 : 0;
`endif
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ !par_ok);
`endif
        drive_bit(stop_bit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        rst_n = 1'b1;

        // 1: idle line
        repeat (100) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rx_data", {24'd0, rx_data}, 32'h00);
        check("idle_no_valid", n_valid, 0);

        // 2: single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        check("a5_count", n_valid, 1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_no_ferr", n_ferr, 0);
        check("a5_busy", {31'd0, busy}, 32'd0);

        // 3: back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        check("b2b_count", n_valid, 3);
        check("b2b_data", {24'd0, rx_data}, 32'hFF);

        // 4: short glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", n_valid, 3);
        check("glitch_no_ferr", n_ferr, 0);

        // 5: framing error, line held low, recovery
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("ferr_count", n_ferr, 1);
        check("ferr_data_kept", {24'd0, rx_data}, 32'hFF);
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        check("ferr_count_after", n_ferr, 1);
        check("recover_data", {24'd0, rx_data}, 32'h55);
        check("recover_count", n_valid, 4);

        // 6: reset during data bit 4 of 8'h81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_data", {24'd0, rx_data}, 32'h00);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        check("post_reset_data", {24'd0, rx_data}, 32'h42);
        check("post_reset_count", n_valid, 5);
        check("post_reset_no_ferr", n_ferr, 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        check("perr_count", n_perr, 1);
        check("perr_data_kept", {24'd0, rx_data}, 32'h42);
        check("perr_no_valid", n_valid, 5);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
